mdu_sequencer: RTL and testbench
================================

// Module: mdu_sequencer
// PURPOSE
//   Sequences the multi-cycle multiply/divide resource in the E stage.
//   Owns HI/LO and the latency counter, and drives busy.
//   Generates md_stall so the D stage holds any HI/LO-touching instruction while the unit is occupied.
//   Replaces free-running busy/stall glue logic with a single controlled FSM.
// PARAMETERS
//   MULT_LAT  5   cycles busy stays high after a mult/multu issues (>=1)
//   DIV_LAT   10  cycles busy stays high after a div/divu issues (>=1)
// PORTS
//   clk       in   1   system clock, rising edge
//   reset     in   1   synchronous, active-high reset
//   op_e      in   4   md op of the instruction in E; 0 = none
//   op_d      in   4   md op of the instruction in D; used only for the stall term
//   d1        in   32  forwarded rs value in E
//   d2        in   32  forwarded rt value in E
//   busy      out  1   high while the unit is in RUN
//   md_stall  out  1   stall request to the PC, D and E registers
//   hi        out  32  architectural HI
//   lo        out  32  architectural LO
// BEHAVIOUR
//   - Op codes: 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
//     Codes 9-15 are treated as 0.
//   - Reset: state=IDLE, cnt=0, busy=0, hi=0, lo=0. Reset mid-RUN aborts the op; its result is discarded.
//   - The E register is bubbled on stall, so each op_e value is present for exactly one cycle.
//     op_e is therefore sampled every cycle.
//   - FSM, IDLE:
//     . op_e in 1..4: capture the 64-bit result into res_hi/res_lo; load cnt=LAT-1; next state RUN.
//     . op_e=7: hi<=d1 at this edge. op_e=8: lo<=d1 at this edge. No state change.
//     . op_e 0, 5 or 6: no action. mf reads are combinational from hi/lo.
//   - FSM, RUN:
//     . busy=1.
//     . cnt!=0: cnt<=cnt-1.
//     . cnt==0: hi<=res_hi, lo<=res_lo, next state IDLE.
//     . Busy lasts exactly LAT cycles, starting the cycle after issue.
//     . The dependent mf in D is released the cycle after busy falls, and reads the new hi/lo.
//   - Any op_e!=0 while in RUN is a protocol violation: it is ignored and flagged by a bench assertion.
//   - md_stall = (op_e in 1..4 || busy) && (op_d != 0). Purely combinational.
//   - Arithmetic:
//     . mult: {hi,lo} = signed d1*d2. multu: unsigned product.
//     . div: lo=quotient, hi=remainder. Truncates toward zero; remainder takes the sign of the dividend.
//     . divu: unsigned quotient and remainder.
//     . 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
//   - Divide by zero (d2==0, op 3/4): hi/lo keep their pre-issue values.
//   - Width of cnt: $clog2(max(MULT_LAT,DIV_LAT)), minimum 1.
// CONFIGURATION
//   MDU_DIV0_FAST_EN
//   - Defined: a divide by zero stays in IDLE. busy never rises, hi/lo are unchanged,
//     and md_stall is asserted only during the issue cycle.
//   - Undefined: a divide by zero occupies the full DIV_LAT busy window, then leaves hi/lo unchanged.
// STRUCTURE
//   - Shared package mdu_pkg:
//     . MD_NONE..MD_MTLO op localparams.
//     . FSM state encoding (IDLE=0, RUN=1).
//     . is_md_start(op) helper function.
//   - One sub-module, mdu_arith: combinational 64-bit mult/div with the signed/unsigned select
//     and the div0/overflow rules. Produces res_hi and res_lo.
//   - The FSM, cnt, hi/lo and md_stall logic live in mdu_sequencer.
// TESTING
//   1. mult d1=0xFFFFFFFE (-2), d2=3, MULT_LAT=5
//      -> busy high for cycles 1..5, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//   2. divu d1=7, d2=2, then mflo in D during busy
//      -> md_stall high for 10 cycles; mflo then reads lo=3, hi=1.
//   3. div d1=0x80000000, d2=0xFFFFFFFF
//      -> lo=0x80000000, hi=0.
//      div d1=-7, d2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   4. mthi 0x1234, then mtlo 0x5678 back-to-back
//      -> hi=0x1234 and lo=0x5678 one edge after each; busy stays 0 throughout.
//   5. div by 0 with hi=0xA, lo=0xB
//      -> macro undefined: 10 busy cycles; macro defined: 0 busy cycles; in both cases hi=0xA, lo=0xB.
//   6. reset asserted in busy cycle 3 of a mult
//      -> next cycle busy=0, hi=lo=0, state IDLE; a following mult completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM state encoding and helpers shared by the multiply/divide sequencer.
package mdu_pkg;
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    function automatic logic [3:0] md_norm(input logic [3:0] op);
        return (op > MD_MTLO) ? MD_NONE : op;
    endfunction

    function automatic logic is_md_start(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic logic is_md_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit signed/unsigned multiply and divide producing the next HI/LO.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);
    logic        sgn_mul;
    logic        sgn_div;
    logic [63:0] prod;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] q_s;
    logic [31:0] r_s;

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
    always_comb begin
        sgn_mul = op == MD_MULT;
        sgn_div = op == MD_DIV;
        prod    = {(sgn_mul && d1[31]) ? 32'hFFFF_FFFF : 32'h0, d1} *
                  {(sgn_mul && d2[31]) ? 32'hFFFF_FFFF : 32'h0, d2};
        a       = (sgn_div && d1[31]) ? -d1 : d1;
        b       = (sgn_div && d2[31]) ? -d2 : d2;
        q       = (b == 32'h0) ? 32'h0 : a / b;
        r       = (b == 32'h0) ? 32'h0 : a % b;
        q_s     = (sgn_div && (d1[31] ^ d2[31])) ? -q : q;
        r_s     = (sgn_div && d1[31]) ? -r : r;
        {res_hi, res_lo} = !is_md_div(op) ? prod :
                           (d2 == 32'h0)  ? {hi, lo} : {r_s, q_s};
    end
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: E-stage multiply/divide FSM owning HI/LO, the latency counter, busy and md_stall.
// MDU_DIV0_FAST_EN: when defined, a divide by zero completes at issue without entering RUN.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op_e,
    input  logic [3:0]  op_d,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic [31:0]     ar_hi, ar_lo;
    logic [3:0]      oe, od;
    logic            start;

    mdu_arith u_arith (
        .op     (oe),
        .d1     (d1),
        .d2     (d2),
        .hi     (hi_q),
        .lo     (lo_q),
        .res_hi (ar_hi),
        .res_lo (ar_lo)
    );

    always_comb begin
        oe       = md_norm(op_e);
        od       = md_norm(op_d);
`ifdef MDU_DIV0_FAST_EN
        start    = is_md_start(oe) && !(is_md_div(oe) && d2 == 32'h0);
`else
        start    = is_md_start(oe);
`endif
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        if (state_q == IDLE) begin
            if (start) begin
                res_hi_d = ar_hi;
                res_lo_d = ar_lo;
                cnt_d    = is_md_div(oe) ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
                state_d  = RUN;
            end else begin
                hi_d = (oe == MD_MTHI) ? d1 : hi_q;
                lo_d = (oe == MD_MTLO) ? d1 : lo_q;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            hi_d    = res_hi_q;
            lo_d    = res_lo_q;
            state_d = IDLE;
        end
        busy     = state_q == RUN;
        md_stall = (is_md_start(oe) || busy) && (od != MD_NONE);
        hi       = hi_q;
        lo       = lo_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed vectors against a cycle-level behavioural model of the MDU sequencer.
module tb_mdu_sequencer;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
`ifdef MDU_DIV0_FAST_EN
    localparam int DIV0_BUSY = 0;
`else
    localparam int DIV0_BUSY = DIV_LAT;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op_e, op_d;
    logic [31:0] d1, d2;
    logic        busy, md_stall;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;
    int busy_cnt, stall_cnt;
    bit started = 0;

    int          m_left = 0;
    bit          p_wr;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    mdu_sequencer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .op_e(op_e), .op_d(op_d), .d1(d1), .d2(d2),
        .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic int nrm(input logic [3:0] op);
        return (op > 4'd8) ? 0 : int'(op);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an issued op occupies the unit for its latency, then commits its result (div0 commits nothing).
    always @(posedge clk) begin
        int          o;
        longint      a, b, pr;
        logic [63:0] up;
        o = nrm(op_e);
        if (reset) begin
            m_left = 0;
            m_hi   = 0;
            m_lo   = 0;
        end else if (m_left > 0) begin
            if (o != 0) begin
                fails++;
                $display("FAIL protocol: op_e=%0d issued while busy at %0t", o, $time);
            end
            m_left--;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (o >= 1 && o <= 4) begin
            p_wr   = 1;
            m_left = (o <= 2) ? MULT_LAT : DIV_LAT;
            if (o == 1) begin
                pr = longint'($signed(d1)) * longint'($signed(d2));
                {p_hi, p_lo} = pr;
            end else if (o == 2) begin
                up = 64'(d1) * 64'(d2);
                {p_hi, p_lo} = up;
            end else if (d2 == 0) begin
                p_wr   = 0;
                m_left = DIV0_BUSY;
            end else begin
                a = (o == 3) ? longint'($signed(d1)) : longint'({32'h0, d1});
                b = (o == 3) ? longint'($signed(d2)) : longint'({32'h0, d2});
                p_lo = 32'(a / b);
                p_hi = 32'(a % b);
            end
        end else if (o == 7) m_hi = d1;
        else if (o == 8) m_lo = d1;
        started = 1;
    end

    always @(negedge clk) begin
        int oe, od;
        if (started) begin
            oe = nrm(op_e);
            od = nrm(op_d);
            check("busy", {31'h0, busy}, {31'h0, m_left > 0});
            check("md_stall", {31'h0, md_stall}, {31'h0, ((oe >= 1 && oe <= 4) || m_left > 0) && od != 0});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    task automatic tick(input logic [3:0] oe, input logic [3:0] od, input logic [31:0] a, input logic [31:0] b);
        op_e = oe;
        op_d = od;
        d1   = a;
        d2   = b;
        @(negedge clk);
        busy_cnt  += int'(busy);
        stall_cnt += int'(md_stall);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(4'd0, 4'd0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);

        busy_cnt = 0;
        tick(4'd1, 4'd0, 32'hFFFF_FFFE, 32'd3);
        idle(6);
        check("mult busy cycles", busy_cnt, 5);
        check("mult hi", hi, 32'hFFFF_FFFF);
        check("mult lo", lo, 32'hFFFF_FFFA);

        busy_cnt  = 0;
        stall_cnt = 0;
        tick(4'd4, 4'd0, 32'd7, 32'd2);
        for (int i = 0; i < 11; i++) tick(4'd0, 4'd6, 32'h0, 32'h0);
        check("divu stall cycles", stall_cnt, 10);
        check("divu busy cycles", busy_cnt, 10);
        tick(4'd6, 4'd0, 32'h0, 32'h0);
        check("divu lo", lo, 32'd3);
        check("divu hi", hi, 32'd1);

        tick(4'd3, 4'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(11);
        check("div ovf lo", lo, 32'h8000_0000);
        check("div ovf hi", hi, 32'h0);
        tick(4'd3, 4'd0, 32'hFFFF_FFF9, 32'd2);
        idle(11);
        check("div -7/2 lo", lo, 32'hFFFF_FFFD);
        check("div -7/2 hi", hi, 32'hFFFF_FFFF);
        tick(4'd3, 4'd0, 32'd7, 32'hFFFF_FFFE);
        idle(11);
        check("div 7/-2 lo", lo, 32'hFFFF_FFFD);
        check("div 7/-2 hi", hi, 32'd1);
        tick(4'd2, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(6);
        check("multu hi", hi, 32'hFFFF_FFFE);
        check("multu lo", lo, 32'd1);
        tick(4'd4, 4'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(11);
        check("divu big lo", lo, 32'h0);
        check("divu big hi", hi, 32'h8000_0000);

        busy_cnt = 0;
        tick(4'd7, 4'd0, 32'h1234, 32'h0);
        check("mthi", hi, 32'h1234);
        tick(4'd8, 4'd0, 32'h5678, 32'h0);
        check("mtlo", lo, 32'h5678);
        check("mthi kept", hi, 32'h1234);
        check("mt busy cycles", busy_cnt, 0);

        tick(4'd7, 4'd0, 32'hA, 32'h0);
        tick(4'd8, 4'd0, 32'hB, 32'h0);
        busy_cnt  = 0;
        stall_cnt = 0;
        tick(4'd3, 4'd5, 32'd5, 32'd0);
        idle(12);
        check("div0 busy cycles", busy_cnt, DIV0_BUSY);
        check("div0 stall cycles", stall_cnt, 1);
        check("div0 hi", hi, 32'hA);
        check("div0 lo", lo, 32'hB);

        tick(4'd1, 4'd0, 32'd5, 32'd6);
        idle(2);
        reset = 1'b1;
        busy_cnt = 0;
        idle(1);
        reset = 1'b0;
        check("abort busy before", busy_cnt, 1);
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort hi", hi, 32'h0);
        check("abort lo", lo, 32'h0);
        tick(4'd1, 4'd0, 32'd3, 32'd4);
        idle(6);
        check("post-reset mult lo", lo, 32'd12);
        check("post-reset mult hi", hi, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
